// File: rtl/cache_miss_handler.sv
// Miss controller between the split I/D caches and unified main memory.
// Hits complete combinationally in IDLE. Misses write back a dirty D-line, fill the D-line, then fill the I-line.
module cache_miss_handler #(
   parameter int TAG_W  = 8,
   parameter int LINE_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_fetch,
   input  logic              re,
   input  logic              we,
   input  logic [15:0]       i_addr,
   input  logic [15:0]       d_addr,
   input  logic [15:0]       wr_data,
   input  logic              i_hit,
   input  logic              d_hit,
   input  logic              d_dirty,
   input  logic [TAG_W-1:0]  d_tag,
   input  logic [LINE_W-1:0] d_line,
   input  logic [LINE_W-1:0] m_line,
   input  logic              m_rdy,
   output logic              i_re,
   output logic              d_re,
   output logic              i_we,
   output logic              d_we,
   output logic              i_dirty_in,
   output logic              d_dirty_in,
   output logic [LINE_W-1:0] i_data,
   output logic [LINE_W-1:0] d_data,
   output logic              m_re,
   output logic              m_we,
   output logic [13:0]       m_addr,
   output logic [LINE_W-1:0] m_data,
   output logic              rdy
);

   localparam int IDX_W = 14 - TAG_W;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] WB    = 2'd1;
   localparam logic [1:0] DFILL = 2'd2;
   localparam logic [1:0] IFILL = 2'd3;

   logic [1:0] state;
   logic [1:0] state_next;
   logic       d_req;
   logic       i_miss;
   logic       d_miss;
   logic       unused_ok;

   // Instruction fetches are line granular, so the word select bits never matter here.
   assign unused_ok = &{1'b0, i_addr[1:0]};

   assign d_req  = re | we;
   assign i_miss = i_fetch & ~i_hit;
   assign d_miss = d_req & ~d_hit;

   function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0] line,
                                                    input logic [1:0]        sel,
                                                    input logic [15:0]       word);
      logic [LINE_W-1:0] res;
      res = line;
      res[{sel, 4'b0000} +: 16] = word;
      return res;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Every output is held low while reset is asserted, so a memory request in flight is abandoned.
   always_comb begin
      state_next = state;
      i_re       = 1'b0;
      d_re       = 1'b0;
      i_we       = 1'b0;
      d_we       = 1'b0;
      i_dirty_in = 1'b0;
      d_dirty_in = 1'b0;
      i_data     = '0;
      d_data     = '0;
      m_re       = 1'b0;
      m_we       = 1'b0;
      m_addr     = '0;
      m_data     = '0;
      rdy        = 1'b0;
      if (rst_n) begin
         case (state)
            IDLE: begin
               i_re = i_fetch;
               d_re = d_req;
               rdy  = ~i_miss & ~d_miss;
               if (we && d_hit) begin
                  d_we       = 1'b1;
                  d_data     = merge_word(d_line, d_addr[1:0], wr_data);
                  d_dirty_in = 1'b1;
               end
               // A data miss is serviced first; the instruction miss is picked up on the next IDLE lookup.
               if (d_miss) begin
                  state_next = d_dirty ? WB : DFILL;
               end else if (i_miss) begin
                  state_next = IFILL;
               end
            end
            WB: begin
               m_we   = 1'b1;
               m_addr = {d_tag, d_addr[IDX_W+1:2]};
               m_data = d_line;
               if (m_rdy) begin
                  state_next = DFILL;
               end
            end
            DFILL: begin
               m_re   = 1'b1;
               m_addr = d_addr[15:2];
               if (m_rdy) begin
                  d_we       = 1'b1;
                  d_data     = we ? merge_word(m_line, d_addr[1:0], wr_data) : m_line;
                  d_dirty_in = we;
                  state_next = IDLE;
               end
            end
            IFILL: begin
               m_re   = 1'b1;
               m_addr = i_addr[15:2];
               if (m_rdy) begin
                  i_we       = 1'b1;
                  i_data     = m_line;
                  state_next = IDLE;
               end
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cache_miss_handler.sv
// Self-checking bench for cache_miss_handler: a job-queue model checked every cycle,
// directed scenarios with literal expectations, and a latency-programmable memory responder.
module tb_cache_miss_handler;

   localparam int JOB_WB    = 1;
   localparam int JOB_DFILL = 2;
   localparam int JOB_IFILL = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        i_fetch = 1'b0;
   logic        re = 1'b0;
   logic        we = 1'b0;
   logic [15:0] i_addr = '0;
   logic [15:0] d_addr = '0;
   logic [15:0] wr_data = '0;
   logic        i_hit = 1'b0;
   logic        d_hit = 1'b0;
   logic        d_dirty = 1'b0;
   logic [7:0]  d_tag = '0;
   logic [63:0] d_line = '0;
   logic [63:0] m_line = '0;
   logic        m_rdy = 1'b0;
   logic        i_re;
   logic        d_re;
   logic        i_we;
   logic        d_we;
   logic        i_dirty_in;
   logic        d_dirty_in;
   logic [63:0] i_data;
   logic [63:0] d_data;
   logic        m_re;
   logic        m_we;
   logic [13:0] m_addr;
   logic [63:0] m_data;
   logic        rdy;

   int checks = 0;
   int failures = 0;
   int lat = 4;
   int cnt = 0;
   logic manual = 1'b0;
   int job_q[$];

   logic        s_rdy;
   logic        s_i_we;
   logic        s_d_we;
   logic        s_m_re;
   logic        s_m_we;
   logic        s_d_dirty_in;
   logic [13:0] s_m_addr;
   logic [63:0] s_d_data;
   logic [63:0] s_i_data;
   logic [63:0] s_m_data;

   cache_miss_handler #(.TAG_W(8), .LINE_W(64)) dut (
      .clk(clk), .rst_n(rst_n), .i_fetch(i_fetch), .re(re), .we(we),
      .i_addr(i_addr), .d_addr(d_addr), .wr_data(wr_data),
      .i_hit(i_hit), .d_hit(d_hit), .d_dirty(d_dirty), .d_tag(d_tag),
      .d_line(d_line), .m_line(m_line), .m_rdy(m_rdy),
      .i_re(i_re), .d_re(d_re), .i_we(i_we), .d_we(d_we),
      .i_dirty_in(i_dirty_in), .d_dirty_in(d_dirty_in),
      .i_data(i_data), .d_data(d_data), .m_re(m_re), .m_we(m_we),
      .m_addr(m_addr), .m_data(m_data), .rdy(rdy)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] put_word(input logic [63:0] line, input logic [1:0] w,
                                            input logic [15:0] v);
      int sh;
      sh = 16 * int'(w);
      return (line & ~(64'hFFFF << sh)) | ({48'd0, v} << sh);
   endfunction

   // Model: an empty queue means the controller is doing lookups; otherwise the head job is in service.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         job_q.delete();
      end else if (job_q.size() == 0) begin
         if ((re || we) && !d_hit) begin
            if (d_dirty) job_q.push_back(JOB_WB);
            job_q.push_back(JOB_DFILL);
         end else if (i_fetch && !i_hit) begin
            job_q.push_back(JOB_IFILL);
         end
      end else if (m_rdy) begin
         void'(job_q.pop_front());
      end
   end

   always @(negedge clk) begin
      logic        e_i_re, e_d_re, e_i_we, e_d_we, e_m_re, e_m_we, e_rdy, e_d_dirty;
      logic [13:0] e_m_addr;
      logic [63:0] e_d_data, e_i_data;
      e_i_re = 0; e_d_re = 0; e_i_we = 0; e_d_we = 0; e_m_re = 0; e_m_we = 0; e_rdy = 0; e_d_dirty = 0;
      e_m_addr = '0; e_d_data = '0; e_i_data = '0;
      if (!rst_n) begin
         check_output("reset_strobes", 64'({i_re, d_re, i_we, d_we, i_dirty_in, d_dirty_in, m_re, m_we, rdy}), 64'd0);
         check_output("reset_m_addr", 64'(m_addr), 64'd0);
         check_output("reset_buses", i_data | d_data | m_data, 64'd0);
      end else begin
         if (job_q.size() == 0) begin
            e_i_re = i_fetch;
            e_d_re = re | we;
            e_rdy  = (!i_fetch || i_hit) && (!(re || we) || d_hit);
            if (we && d_hit) begin
               e_d_we = 1; e_d_dirty = 1;
               e_d_data = put_word(d_line, d_addr[1:0], wr_data);
            end
         end else if (job_q[0] == JOB_WB) begin
            e_m_we = 1;
            e_m_addr = 14'((d_tag * 64) + ((d_addr / 4) % 64));
         end else if (job_q[0] == JOB_DFILL) begin
            e_m_re = 1;
            e_m_addr = 14'(d_addr / 4);
            if (m_rdy) begin
               e_d_we = 1; e_d_dirty = we;
               e_d_data = we ? put_word(m_line, d_addr[1:0], wr_data) : m_line;
            end
         end else begin
            e_m_re = 1;
            e_m_addr = 14'(i_addr / 4);
            if (m_rdy) begin
               e_i_we = 1;
               e_i_data = m_line;
            end
         end
         check_output("model_strobes", 64'({i_re, d_re, i_we, d_we, m_re, m_we, rdy, i_dirty_in}),
                      64'({e_i_re, e_d_re, e_i_we, e_d_we, e_m_re, e_m_we, e_rdy, 1'b0}));
         if (e_d_we) begin
            check_output("model_d_data", d_data, e_d_data);
            check_output("model_d_dirty_in", 64'(d_dirty_in), 64'(e_d_dirty));
         end
         if (e_i_we) check_output("model_i_data", i_data, e_i_data);
         if (e_m_re || e_m_we) check_output("model_m_addr", 64'(m_addr), 64'(e_m_addr));
         if (e_m_we) check_output("model_m_data", m_data, d_line);
      end
   end

   // One cycle: sample outputs mid-cycle, then after the edge run the memory responder and cache updates.
   task automatic tick();
      @(negedge clk);
      s_rdy = rdy; s_i_we = i_we; s_d_we = d_we; s_m_re = m_re; s_m_we = m_we;
      s_d_dirty_in = d_dirty_in; s_m_addr = m_addr; s_d_data = d_data; s_i_data = i_data; s_m_data = m_data;
      @(posedge clk);
      #2;
      if (!rst_n || manual) cnt = 0;
      if (!manual) begin
         if (m_rdy) cnt = 0;
         m_rdy = 1'b0;
         if (rst_n && (m_re || m_we)) begin
            cnt++;
            if (cnt == lat) m_rdy = 1'b1;
         end
      end
      if (s_d_we) begin d_hit = 1'b1; d_dirty = s_d_dirty_in; d_line = s_d_data; end
      if (s_i_we) i_hit = 1'b1;
   endtask

   task automatic wait_ready(input int max_cycles, output int stalled);
      stalled = 0;
      tick();
      while (!s_rdy && stalled < max_cycles) begin
         stalled++;
         tick();
      end
      if (!s_rdy) begin
         failures++;
         checks++;
         $display("[TB] FAIL wait_ready_timeout actual=stalled expected=rdy within %0d", max_cycles);
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog actual=running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int stalled;
      $display("[TB] cache_miss_handler bench start");
      #3;
      rst_n = 1'b0; i_fetch = 1'b1; i_hit = 1'b1;
      tick(); tick();
      check_output("reset_rdy", 64'(s_rdy), 64'd0);
      check_output("reset_m_addr_lit", 64'(s_m_addr), 64'd0);
      rst_n = 1'b1;
      tick();
      check_output("first_cycle_rdy", 64'(s_rdy), 64'd1);

      re = 1'b1; d_hit = 1'b1; d_addr = 16'h0040;
      tick();
      check_output("read_hit_rdy", 64'(s_rdy), 64'd1);
      check_output("read_hit_mem", 64'({s_m_re, s_m_we}), 64'd0);
      check_output("read_hit_writes", 64'({s_i_we, s_d_we}), 64'd0);

      re = 1'b0; we = 1'b1; d_addr = 16'h1236; wr_data = 16'hBEEF; d_line = 64'h4444_3333_2222_1111;
      tick();
      check_output("write_hit_d_we", 64'(s_d_we), 64'd1);
      check_output("write_hit_d_data", s_d_data, 64'h4444_BEEF_2222_1111);
      check_output("write_hit_dirty", 64'(s_d_dirty_in), 64'd1);
      check_output("write_hit_rdy", 64'(s_rdy), 64'd1);
      we = 1'b0;

      lat = 4; re = 1'b1; d_addr = 16'hB104; d_tag = 8'h12; d_dirty = 1'b1; d_hit = 1'b0;
      d_line = 64'hDEAD_BEEF_CAFE_F00D; m_line = 64'h0123_4567_89AB_CDEF;
      for (int c = 0; c < 10; c++) begin
         tick();
         check_output("dirty_rdy", 64'(s_rdy), 64'(c == 9));
         if (c >= 1 && c <= 4) begin
            check_output("dirty_wb_m_we", 64'({s_m_we, s_m_re}), 64'b10);
            check_output("dirty_wb_m_addr", 64'(s_m_addr), 64'h0481);
            check_output("dirty_wb_m_data", s_m_data, 64'hDEAD_BEEF_CAFE_F00D);
         end
         if (c >= 5 && c <= 8) begin
            check_output("dirty_fill_m_re", 64'({s_m_we, s_m_re}), 64'b01);
            check_output("dirty_fill_m_addr", 64'(s_m_addr), 64'h2C41);
         end
         if (c == 8) begin
            check_output("dirty_fill_d_we", 64'(s_d_we), 64'd1);
            check_output("dirty_fill_dirty_in", 64'(s_d_dirty_in), 64'd0);
            check_output("dirty_fill_d_data", s_d_data, 64'h0123_4567_89AB_CDEF);
         end
         if (c < 8) check_output("dirty_no_early_d_we", 64'(s_d_we), 64'd0);
      end

      lat = 3; d_addr = 16'h0F08; d_hit = 1'b0; d_dirty = 1'b0;
      i_addr = 16'h5A7C; i_hit = 1'b0; m_line = 64'hAAAA_BBBB_CCCC_DDDD;
      for (int c = 0; c < 9; c++) begin
         tick();
         check_output("both_rdy", 64'(s_rdy), 64'(c == 8));
         if (c == 1) check_output("both_dfill_m_addr", 64'({s_m_re, s_m_addr}), 64'({1'b1, 14'h03C2}));
         if (c == 3) check_output("both_dfill_d_we", 64'({s_d_we, s_i_we}), 64'b10);
         if (c == 4) check_output("both_gap_idle", 64'({s_m_re, s_m_we}), 64'd0);
         if (c == 5) check_output("both_ifill_m_addr", 64'({s_m_re, s_m_addr}), 64'({1'b1, 14'h169F}));
         if (c == 7) begin
            check_output("both_ifill_i_we", 64'({s_i_we, s_d_we}), 64'b10);
            check_output("both_ifill_i_data", s_i_data, 64'hAAAA_BBBB_CCCC_DDDD);
         end
      end

      lat = 2; i_fetch = 1'b0; re = 1'b0; we = 1'b1; d_addr = 16'h2003; wr_data = 16'h5555;
      d_hit = 1'b0; d_dirty = 1'b0; m_line = 64'h1111_2222_3333_4444;
      for (int c = 0; c < 4; c++) begin
         tick();
         check_output("store_miss_rdy", 64'(s_rdy), 64'(c == 3));
         if (c == 2) begin
            check_output("store_miss_d_data", s_d_data, 64'h5555_2222_3333_4444);
            check_output("store_miss_dirty_in", 64'({s_d_we, s_d_dirty_in}), 64'b11);
         end
      end
      we = 1'b0;

      lat = 5; re = 1'b1; d_addr = 16'h3000; d_hit = 1'b0; d_dirty = 1'b0;
      tick(); tick(); tick();
      check_output("pre_reset_in_fill", 64'(s_m_re), 64'd1);
      manual = 1'b1; rst_n = 1'b0;
      tick();
      check_output("mid_reset_outputs", 64'({s_rdy, s_m_re, s_d_we}), 64'd0);
      rst_n = 1'b1; re = 1'b0;
      tick();
      check_output("post_reset_idle", 64'({s_rdy, s_m_re}), 64'b10);
      m_rdy = 1'b1;
      tick();
      check_output("stale_m_rdy_ignored", 64'({s_rdy, s_m_re, s_d_we}), 64'b100);
      m_rdy = 1'b0;
      tick();
      check_output("no_spurious_transition", 64'({s_rdy, s_m_re, s_m_we}), 64'b100);
      manual = 1'b0;

      lat = 2; i_fetch = 1'b1; i_hit = 1'b0; i_addr = 16'hFFF1;
      wait_ready(20, stalled);
      check_output("imiss_stall_cycles", 64'(stalled), 64'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cache_miss_handler.md
# cache_miss_handler

Controller between the split I/D caches and the unified main memory. Each cycle it checks the instruction and data cache lookups and raises `rdy` when both hit. On a miss it writes back a dirty D-line, fills the missing line from memory, and merges store data into D-lines. The pipeline stalls on `rdy=0`.

## Interface
Parameters:
- `TAG_W`, 8: cache tag width; index width = 14 − TAG_W.
- `LINE_W`, 64: line width, four 16-bit words.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset. One clock domain only.
- `i_fetch` in 1: instruction fetch request.
- `re`, `we` in 1: data read / data write request.
- `i_addr`, `d_addr` in 16: word addresses.
- `wr_data` in 16: store data.
- `i_hit`, `d_hit`, `d_dirty` in 1: cache lookup results for the current index.
- `d_tag` in TAG_W: tag of the resident D-line.
- `d_line`, `m_line` in 64: resident D-line / memory read line.
- `m_rdy` in 1: memory access complete; one-cycle pulse.
- `i_re`, `d_re`, `i_we`, `d_we` out 1: cache read/write strobes.
- `i_dirty_in`, `d_dirty_in` out 1: dirty bit written with the line.
- `i_data`, `d_data` out 64: line written into each cache.
- `m_re`, `m_we` out 1: memory read/write request.
- `m_addr` out 14: memory line address.
- `m_data` out 64: write-back line.
- `rdy` out 1: both requests are satisfied this cycle.

## Operation
- Word `w` = addr[1:0] occupies line bits [16w+15:16w].
- Index = addr[7:2]; tag = addr[15:8].
- FSM states:
  - IDLE: lookup.
  - WB: D-line write-back.
  - DFILL: D-line fill.
  - IFILL: I-line fill.
- IDLE:
  - `i_re=i_fetch`, `d_re=re|we`.
  - `rdy = (!i_fetch|i_hit) & (!(re|we)|d_hit)`.
  - Write hit (`we & d_hit`): `d_we=1`, `d_data` = `d_line` with word `d_addr[1:0]` replaced by `wr_data`, `d_dirty_in=1`.
  - Priority when both miss: data first.
  - Data miss with `d_dirty=1` → WB; data miss with `d_dirty=0` → DFILL.
  - Else instruction miss → IFILL.
  - `re` and `we` both high: treated as a write.
- WB:
  - `m_we=1`, `m_addr={d_tag,d_addr[7:2]}`, `m_data=d_line`.
  - Hold until `m_rdy`, then → DFILL.
- DFILL:
  - `m_re=1`, `m_addr=d_addr[15:2]`.
  - On `m_rdy`: `d_we=1`, `d_data=m_line` (word replaced by `wr_data` if `we`), `d_dirty_in=we` → IDLE.
- IFILL:
  - `m_re=1`, `m_addr=i_addr[15:2]`.
  - On `m_rdy`: `i_we=1`, `i_data=m_line`, `i_dirty_in=0` → IDLE.
- A pending instruction miss is serviced on the IDLE cycle after a data fill, since I lookup is re-evaluated there.
- `rdy=0` in every non-IDLE state.
- Upstream holds `i_fetch`/`re`/`we`/addresses/`wr_data` stable while `rdy=0`. Changes mid-miss are unsupported.
- `m_re`/`m_we` are never both high. Each stays high continuously until `m_rdy`.
- `m_rdy` outside WB/DFILL/IFILL is ignored.
- Reset (async, any state):
  - State → IDLE.
  - All outputs forced 0 while `rst_n=0`: `rdy`, strobes, `m_addr`, data buses.
  - An in-flight memory request is abandoned. Its `m_rdy` arriving after reset is ignored.

## Timing
- Hit (read or write): `rdy` in the same cycle (combinational). The write lands at the next clk edge.
- Clean miss: 1 IDLE cycle + L cycles in FILL (L = memory latency to `m_rdy`) + 1 IDLE hit cycle. Total stall = L+1 cycles.
- Dirty miss: adds L cycles of WB.
- I+D miss: the two services run back to back, separated by one IDLE cycle.
- State register and transitions update on posedge `clk`. Outputs are Moore-style except the IDLE hit/write path and the `m_rdy`-qualified cache writes.

## Test plan
- Reset: hold `rst_n=0` with `i_fetch=1`, `i_hit=1` → all outputs 0. Release → `rdy=1` in the first cycle.
- Read hit: `re=1`, `d_hit=1`, `i_fetch=1`, `i_hit=1` → `rdy=1`, no `m_re`/`m_we`, no cache writes.
- Write hit: `d_addr=16'h1236`, `wr_data=16'hBEEF`, `d_line=64'h4444_3333_2222_1111` → `d_we=1`, `d_data=64'h4444_BEEF_2222_1111`, `d_dirty_in=1`, `rdy=1`.
- Dirty read miss, L=4:
  - Setup: `d_addr=16'hB104`, `d_tag=8'h12`, `d_dirty=1`.
  - WB: `m_we=1`, `m_addr=14'h0481`, `m_data=d_line` for 4 cycles.
  - DFILL: `m_re=1`, `m_addr=14'h2C41`; on `m_rdy`, `d_we=1`, `d_dirty_in=0`, `d_data=m_line`.
  - `rdy=0` throughout, returning to 1 one cycle later.
- Simultaneous I and D clean miss: DFILL completes first, then one IDLE cycle, then IFILL with `m_addr=i_addr[15:2]` and `i_we` on `m_rdy`. `rdy=1` only after both.
- Reset mid-DFILL: drop `rst_n` two cycles into the fill, then pulse `m_rdy` after release → no `d_we`, state IDLE, no spurious transition.
